vram_fetch_streamer: RTL and testbench

- Read-only requester that fetches a run of consecutive 32-bit VRAM words through one 32-bit port (if1/if2/if3) of the VRAM arbiter.
- Buffers the words in a small FIFO for a downstream renderer (layer or sprite line builder).
- Keeps the arbiter port busy every cycle it is granted, with no lost or duplicated words under preemption by higher-priority ports.

---
 rtl/vram_fetch_streamer.sv | 130 +++++++++++++
 tb/tb_vram_fetch_streamer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_streamer.sv
// rtl/vram_fetch_streamer.sv - VRAM run fetcher feeding a first-word-fall-through FIFO
// Issues one read strobe per cycle while a run is pending and the FIFO can absorb the returning word.
module vram_fetch_streamer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [14:0]      start_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [14:0]      vram_addr,
    output logic             vram_strobe,
    input  logic             vram_ack,
    input  logic [31:0]      vram_rddata,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [14:0]      r_cur_addr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_done;
    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;

    logic             w_fetch;
    logic             w_ack;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [CNT_W-1:0] w_rem_eff;
    logic [LVL_W:0]   w_level_eff;

    // An ack only counts while fetching; late acks after abort or reset land in IDLE and are dropped.
    assign w_fetch     = (r_state == S_FETCH);
    assign w_ack       = w_fetch && vram_ack;
    assign w_rem_eff   = r_remaining - CNT_W'(w_ack);
    assign w_level_eff = {1'b0, r_level} + (LVL_W + 1)'(w_ack);
    assign w_push      = w_ack && !abort;
    assign w_pop       = out_valid && out_ready;
    assign w_last      = w_ack && (r_remaining == CNT_W'(1));

    // Space check ignores a same-cycle pop so the word returning next cycle always fits.
    assign vram_addr   = r_cur_addr + 15'(w_ack);
    assign vram_strobe = w_fetch && (w_rem_eff != '0) &&
                         (w_level_eff <= (LVL_W + 1)'(DEPTH - 1));
    assign busy        = w_fetch;
    assign done        = r_done;
    assign out_valid   = (r_level != '0);
    assign out_data    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start && (word_count != '0)) w_state_next = S_FETCH;
                S_FETCH: if (w_last) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_remaining <= '0;
            end else if (r_state == S_IDLE) begin
                if (start) begin
                    r_cur_addr  <= start_addr;
                    r_remaining <= word_count;
                    r_done      <= (word_count == '0);
                end
            end else if (w_ack) begin
                r_cur_addr  <= r_cur_addr + 15'd1;
                r_remaining <= r_remaining - CNT_W'(1);
                r_done      <= w_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= vram_rddata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fetch_streamer.sv
// tb/tb_vram_fetch_streamer.sv - bench for vram_fetch_streamer
// Arbiter and consumer are emulated; a run-level model tracks expected FIFO contents and pulses.
module tb_vram_fetch_streamer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [14:0]      start_addr = '0;
    logic [CNT_W-1:0] word_count = '0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic [14:0]      vram_addr;
    logic             vram_strobe;
    logic             vram_ack = 1'b0;
    logic [31:0]      vram_rddata = '0;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;

    vram_fetch_streamer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .vram_addr(vram_addr), .vram_strobe(vram_strobe), .vram_ack(vram_ack),
        .vram_rddata(vram_rddata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // run-level model
    bit          m_active = 0;
    bit          m_done_due = 0;
    int          m_idx = 0;
    int          m_count = 0;
    logic [14:0] m_base = '0;
    logic [31:0] q[$];

    // arbiter / consumer controls and observations
    int          grant_pct = 100;
    int          ready_pct = 100;
    logic [31:0] deny_mask = '0;
    bit          force_grant = 0;
    int          strobe_n = 0;
    logic [14:0] pend_addr = '0;
    int          n_acks = 0;
    int          n_done = 0;
    int          n_pops = 0;
    logic [14:0] first_ack = '0;
    logic [14:0] last_ack = '0;

    typedef struct {
        logic [14:0] addr;
        int          count;
        logic [31:0] deny;
        int          rdy;
        int          exp_acks;
        logic [14:0] exp_first;
        logic [14:0] exp_last;
        int          exp_done;
    } vec_t;

    function automatic logic [31:0] memv(input logic [14:0] a);
        return (32'(a) * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        int  ack_i;
        bit  exp_strobe;
        bit  g;
        bit  deny;
        @(negedge clk);
        ack_i = (vram_ack && m_active) ? 1 : 0;
        chk("busy", busy, m_active);
        chk("done", done, m_done_due);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        exp_strobe = m_active && ((m_count - m_idx - ack_i) != 0) && ((q.size() + ack_i) <= DEPTH - 1);
        chk("strobe", vram_strobe, exp_strobe);
        if (exp_strobe) chk("vram_addr", vram_addr, 15'(32'(m_base) + m_idx + ack_i));
        if (done) n_done++;

        m_done_due = 0;
        if (rst || abort) begin
            q.delete();
            m_active = 0;
        end else begin
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                n_pops++;
            end
            if (m_active) begin
                if (ack_i != 0) begin
                    q.push_back(memv(15'(32'(m_base) + m_idx)));
                    m_idx++;
                    n_acks++;
                    if (n_acks == 1) first_ack = pend_addr;
                    last_ack = pend_addr;
                    if (m_idx == m_count) begin
                        m_active = 0;
                        m_done_due = 1;
                    end
                end
            end else if (start) begin
                m_base  = start_addr;
                m_count = int'(word_count);
                m_idx   = 0;
                if (m_count == 0) m_done_due = 1;
                else m_active = 1;
            end
        end

        g = 0;
        if (vram_strobe) begin
            deny = (strobe_n < 32) ? deny_mask[strobe_n] : 1'b0;
            strobe_n++;
            g = force_grant || (!deny && ($urandom_range(99) < grant_pct));
            pend_addr = vram_addr;
        end
        @(posedge clk);
        #1;
        vram_ack    = g;
        vram_rddata = g ? memv(pend_addr) : $urandom();
        start       = 0;
        abort       = 0;
        force_grant = 0;
        out_ready   = ($urandom_range(99) < ready_pct);
    endtask

    task automatic begin_run(input logic [14:0] a, input int cnt);
        start_addr = a;
        word_count = CNT_W'(cnt);
        start      = 1;
        n_acks = 0; n_done = 0; n_pops = 0; strobe_n = 0;
        cycle();
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((m_active || q.size() != 0 || m_done_due) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: run still active after %0d cycles", budget);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{15'h0100, 4, 32'h0, 100, 4, 15'h0100, 15'h0103, 1};
        vecs[1] = '{15'h0200, 6, 32'hA, 100, 6, 15'h0200, 15'h0205, 1};
        vecs[2] = '{15'h7FFE, 3, 32'h0, 100, 3, 15'h7FFE, 15'h0000, 1};
        vecs[3] = '{15'h0300, 0, 32'h0, 100, 0, 15'h0000, 15'h0000, 1};
        vecs[4] = '{15'h0010, 20, 32'h5555, 50, 20, 15'h0010, 15'h0023, 1};

        rst = 1;
        repeat (2) cycle();
        rst = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_strobe", vram_strobe, 1'b0);

        for (int i = 0; i < 5; i++) begin
            grant_pct = 100;
            ready_pct = vecs[i].rdy;
            deny_mask = vecs[i].deny;
            begin_run(vecs[i].addr, vecs[i].count);
            run_until_idle(500);
            chk($sformatf("v%0d_acks", i), n_acks, vecs[i].exp_acks);
            chk($sformatf("v%0d_pops", i), n_pops, vecs[i].exp_acks);
            chk($sformatf("v%0d_done", i), n_done, vecs[i].exp_done);
            if (vecs[i].exp_acks > 0) begin
                chk($sformatf("v%0d_first", i), first_ack, vecs[i].exp_first);
                chk($sformatf("v%0d_last", i), last_ack, vecs[i].exp_last);
            end else begin
                chk($sformatf("v%0d_nostrobe", i), strobe_n, 0);
            end
        end
        deny_mask = '0;

        // consumer stalled: FIFO fills to DEPTH and strobing stops
        grant_pct = 100;
        ready_pct = 0;
        begin_run(15'h0400, 12);
        repeat (30) cycle();
        chk("stall_acks", n_acks, 8);
        chk("stall_strobe", vram_strobe, 1'b0);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_busy", busy, 1'b1);
        ready_pct = 100;
        run_until_idle(500);
        chk("stall_total", n_acks, 12);
        chk("stall_pops", n_pops, 12);
        chk("stall_done", n_done, 1);

        // abort with a grant in flight; start while busy and start with abort are dropped
        begin_run(15'h0500, 6);
        repeat (2) cycle();
        start_addr = 15'h0600; word_count = CNT_W'(2); start = 1;
        cycle();
        abort = 1; start = 1; force_grant = 1;
        chk("abort_strobe", vram_strobe, 1'b1);
        cycle();
        chk("abort_late_ack", vram_ack, 1'b1);
        repeat (4) cycle();
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", n_done, 0);

        // reset mid-run with a grant in flight
        begin_run(15'h0700, 5);
        repeat (2) cycle();
        rst = 1; force_grant = 1;
        cycle();
        rst = 0;
        repeat (3) cycle();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_strobe", vram_strobe, 1'b0);
        chk("mrst_done", n_done, 0);

        // randomized runs against the model
        for (int r = 0; r < 20; r++) begin
            int cnt;
            grant_pct = 70;
            ready_pct = 60;
            cnt = int'($urandom_range(40, 1));
            begin_run(15'($urandom()), cnt);
            if (r % 4 == 3) begin
                repeat (int'($urandom_range(12, 1))) cycle();
                abort = 1;
                cycle();
                run_until_idle(100);
            end else begin
                run_until_idle(2000);
                chk($sformatf("rnd%0d_acks", r), n_acks, cnt);
                chk($sformatf("rnd%0d_done", r), n_done, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
